// File: rtl/tia_object_position_counter.sv
// Horizontal position counter for TIA movable objects (missiles, ball,
// player start logic).
//
// A pixel phase divider advances an XNOR LFSR step counter. The counter
// wraps once per scan line, and the step that enters index 0 starts the main
// copy of the object. Close, medium and wide copies start on the steps that
// enter indices 4, 8 and 16. Each start loads a width counter, and that
// counter drives the registered serial output for 1, 2, 4 or 8 advances.
//
// Build option: define OBJ_COPY_DECODE_EN to decode the NUSIZ copy code.
// When it is undefined, the copies port is ignored and the design produces
// only the main copy.
//
// Control inputs are plain level/strobe signals with no handshake. Where
// several act in one clk, they take priority in this order: reset_bar, then
// obj_reset/lock, then adv.
module tia_object_position_counter #(
  parameter int LFSR_WIDTH   = 6,
  parameter int PERIOD_STEPS = 40,
  parameter int PHASE_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  reset_bar,
  input  logic                  pix_en,
  input  logic                  count_en,
  input  logic                  extra_clk,
  input  logic                  obj_reset,
  input  logic                  lock,
  input  logic                  enable,
  input  logic [1:0]            size,
  input  logic [2:0]            copies,
  output logic                  obj_out,
  output logic                  wrap_pulse,
  output logic [LFSR_WIDTH-1:0] lfsr_state
);

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] q);
    return {q[LFSR_WIDTH-2:0], ~(q[LFSR_WIDTH-1] ^ q[LFSR_WIDTH-2])};
  endfunction

  // LFSR value after k advances from zero; evaluated at elaboration only.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_at(input int k);
    logic [LFSR_WIDTH-1:0] q;
    q = '0;
    for (int i = 0; i < k; i++) q = lfsr_next(q);
    return q;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] LAST_Q = lfsr_at(PERIOD_STEPS - 1);

  logic [PHASE_BITS-1:0] phase;
  logic [LFSR_WIDTH-1:0] q;
  logic [3:0]            wcnt;

  logic                  pix_adv;
  logic                  adv;
  logic                  clr;
  logic [1:0]            inc;
  logic [PHASE_BITS:0]   phase_sum;
  logic                  step;
  logic                  at_last;
  logic                  lockup;
  logic [LFSR_WIDTH-1:0] q_next;
  logic                  wrap_step;
  logic                  copy_hit;
  logic                  start;
  logic [3:0]            wload;

  // A pixel advance and an HMOVE extra clock in the same clk add two to
  // the phase. The carry out of the phase steps the LFSR at most once per
  // clk, and the remainder stays in the phase.
  assign pix_adv   = pix_en & count_en & ~lock;
  assign adv       = pix_adv | extra_clk;
  assign clr       = obj_reset | lock;
  assign inc       = {1'b0, pix_adv} + {1'b0, extra_clk};
  assign phase_sum = {1'b0, phase} + (PHASE_BITS + 1)'(inc);
  assign step      = phase_sum[PHASE_BITS];

  // Last index of the line and the all-ones lock-up state both fall back
  // to zero. Only the real end of line is reported as a wrap.
  assign at_last   = (q == LAST_Q);
  assign lockup    = &q;
  assign q_next    = (at_last || lockup) ? '0 : lfsr_next(q);
  assign wrap_step = step & at_last;

`ifdef OBJ_COPY_DECODE_EN
  localparam logic [LFSR_WIDTH-1:0] AT3  = lfsr_at(3);
  localparam logic [LFSR_WIDTH-1:0] AT7  = lfsr_at(7);
  localparam logic [LFSR_WIDTH-1:0] AT15 = lfsr_at(15);
  localparam logic OK4  = (PERIOD_STEPS > 4);
  localparam logic OK8  = (PERIOD_STEPS > 8);
  localparam logic OK16 = (PERIOD_STEPS > 16);

  logic c4, c8, c16;

  // NUSIZ copy code to the set of copy offsets; codes 101/111 are main only.
  always_comb begin
    c4  = 1'b0;
    c8  = 1'b0;
    c16 = 1'b0;
    case (copies)
      3'b001: c4 = 1'b1;
      3'b010: c8 = 1'b1;
      3'b011: begin c4 = 1'b1; c8 = 1'b1; end
      3'b100: c16 = 1'b1;
      3'b110: begin c8 = 1'b1; c16 = 1'b1; end
      default: ;
    endcase
  end

  // Copies start on the step that enters their index, so the decodes
  // compare against the value one index earlier.
  assign copy_hit = (c4  & OK4  & (q == AT3))  |
                    (c8  & OK8  & (q == AT7))  |
                    (c16 & OK16 & (q == AT15));
`else
  logic copies_unused;
  assign copies_unused = ^copies;
  assign copy_hit      = 1'b0;
`endif

  assign start = wrap_step | (step & copy_hit);
  assign wload = 4'b0001 << size;

  // Position, wrap and width state. obj_reset/lock act as a synchronous
  // clear that overrides any advance in the same clk.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      phase      <= '0;
      q          <= '0;
      wcnt       <= '0;
      obj_out    <= 1'b0;
      wrap_pulse <= 1'b0;
    end else if (clr) begin
      phase      <= '0;
      q          <= '0;
      wcnt       <= '0;
      obj_out    <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      phase      <= phase_sum[PHASE_BITS-1:0];
      wrap_pulse <= wrap_step;
      if (step) q <= q_next;
      if (adv) obj_out <= enable & (wcnt != 4'd0);
      if (start) wcnt <= wload;
      else if (adv && (wcnt != 4'd0)) wcnt <= wcnt - 4'd1;
    end
  end

  assign lfsr_state = q;

endmodule

// File: tb/tb_tia_object_position_counter.sv
// Directed bench for tia_object_position_counter with default parameters
// (40 steps x 4 pixels = 160 cycles per line). Expected values are
// hand-derived from the line timing. Copy expectations follow
// OBJ_COPY_DECODE_EN.
module tb_tia_object_position_counter;

  logic       clk = 1'b0;
  logic       reset_bar;
  logic       pix_en, count_en, extra_clk, obj_reset, lock, enable;
  logic [1:0] size;
  logic [2:0] copies;
  logic       obj_out, wrap_pulse;
  logic [5:0] lfsr_state;

  int total = 0;
  int bad   = 0;
  int n;
  logic [0:0] exp_q[$];

  tia_object_position_counter dut (
    .clk        (clk),
    .reset_bar  (reset_bar),
    .pix_en     (pix_en),
    .count_en   (count_en),
    .extra_clk  (extra_clk),
    .obj_reset  (obj_reset),
    .lock       (lock),
    .enable     (enable),
    .size       (size),
    .copies     (copies),
    .obj_out    (obj_out),
    .wrap_pulse (wrap_pulse),
    .lfsr_state (lfsr_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_obj_reset();
    obj_reset = 1'b1;
    tick();
    obj_reset = 1'b0;
  endtask

  // Expected copy offsets {+16, +8, +4} for a NUSIZ code.
  function automatic logic [2:0] copy_mask(input logic [2:0] c);
`ifdef OBJ_COPY_DECODE_EN
    case (c)
      3'b001:  return 3'b001;
      3'b010:  return 3'b010;
      3'b011:  return 3'b011;
      3'b100:  return 3'b100;
      3'b110:  return 3'b110;
      default: return 3'b000;
    endcase
`else
    return c & 3'b000;
`endif
  endfunction

  // True when cycle t (after a start at cycle s) lies inside a 2^sz burst.
  function automatic logic in_burst(input int t, input int s, input int sz);
    return (t > s) && (t <= s + (1 << sz));
  endfunction

  // Called just after a wrap_pulse sample. Runs one full line, checking
  // obj_out every cycle and requiring the next wrap exactly 160 cycles later.
  task automatic check_line(input int msz, input int csz, input logic [2:0] m, input string tag);
    logic [159:0] ev, ov;
    int early;
    early = 0;
    for (int t = 1; t <= 160; t++)
      exp_q.push_back(in_burst(t, 0, msz) | (m[0] & in_burst(t, 16, csz)) |
                      (m[1] & in_burst(t, 32, csz)) | (m[2] & in_burst(t, 64, csz)));
    for (int t = 1; t <= 160; t++) begin
      tick();
      ev[t-1] = exp_q.pop_front();
      ov[t-1] = obj_out;
      if (t < 160 && wrap_pulse) early++;
    end
    chk({tag, "_obj"}, ov, ev);
    chk({tag, "_early_wrap"}, early, 0);
    chk({tag, "_wrap"}, wrap_pulse, 1'b1);
  endtask

  // Cycles until the next wrap_pulse, with optional extra_clk pulses at
  // cycles e1/e2 and count_en low for cl cycles starting at cycle cs.
  task automatic measure_gap(input int e1, input int e2, input int cs, input int cl, output int gap);
    gap = 400;
    for (int t = 1; t <= 400; t++) begin
      extra_clk = (t == e1) || (t == e2);
      count_en  = !((t >= cs) && (t < cs + cl));
      tick();
      if (wrap_pulse) begin
        gap = t;
        break;
      end
    end
    extra_clk = 1'b0;
    count_en  = 1'b1;
  endtask

  initial begin
    // Reset.
    reset_bar = 1'b0;
    pix_en = 1'b0; count_en = 1'b0; extra_clk = 1'b0; obj_reset = 1'b0;
    lock = 1'b0; enable = 1'b0; size = 2'd0; copies = 3'd0;
    tick();
    tick();
    chk("rst_obj_out", obj_out, 1'b0);
    chk("rst_wrap", wrap_pulse, 1'b0);
    chk("rst_lfsr", lfsr_state, 6'd0);
    reset_bar = 1'b1;

    // Basic line timing: wrap 160 cycles after obj_reset, 1-pixel object.
    pix_en = 1'b1; count_en = 1'b1; enable = 1'b1;
    pulse_obj_reset();
    chk("clr_lfsr", lfsr_state, 6'd0);
    repeat (4) tick();
    chk("lfsr_step1", lfsr_state, 6'b000001);
    repeat (4) tick();
    chk("lfsr_step2", lfsr_state, 6'b000011);
    measure_gap(0, 0, 0, 0, n);
    chk("first_wrap", n, 152);
    chk("start_no_out_yet", obj_out, 1'b0);
    check_line(0, 0, 3'b000, "line_s0_a");
    check_line(0, 0, 3'b000, "line_s0_b");

    // Width 8 with copies; the new size applies from the next start.
    size = 2'd3; copies = 3'b011;
    measure_gap(0, 0, 0, 0, n);
    chk("settle_gap", n, 160);
    check_line(3, 3, copy_mask(3'b011), "line_c011");
    copies = 3'b110;
    check_line(3, 3, copy_mask(3'b110), "line_c110");
    copies = 3'b101;
    check_line(3, 3, copy_mask(3'b101), "line_c101");
    // Size change right after a start: main keeps 8, the copy uses 2.
    copies = 3'b001; size = 2'd1;
    check_line(3, 1, copy_mask(3'b001), "line_sz_change");
    check_line(1, 1, copy_mask(3'b001), "line_sz1");

    // HMOVE extra clocks shorten the line, count_en low lengthens it.
    size = 2'd0; copies = 3'b000;
    measure_gap(10, 50, 0, 0, n);
    chk("gap_extra2", n, 158);
    measure_gap(0, 0, 30, 10, n);
    chk("gap_hold10", n, 170);
    measure_gap(0, 0, 0, 0, n);
    chk("gap_plain", n, 160);

    // lock mid-burst: output and counter held at zero, restart from index 0.
    size = 2'd3;
    measure_gap(0, 0, 0, 0, n);
    chk("gap_pre_lock", n, 160);
    tick();
    tick();
    chk("pre_lock_out", obj_out, 1'b1);
    for (int i = 0; i < 50; i++) begin
      lock = 1'b1;
      tick();
      chk("lock_hold", {obj_out, lfsr_state}, 7'd0);
    end
    lock = 1'b0;
    measure_gap(0, 0, 0, 0, n);
    chk("gap_after_lock", n, 160);

    // Asynchronous reset mid-burst drops the output without a clock edge.
    size = 2'd2;
    measure_gap(0, 0, 0, 0, n);
    chk("gap_pre_async", n, 160);
    tick();
    tick();
    chk("burst_before_async", obj_out, 1'b1);
    #3;
    reset_bar = 1'b0;
    #1;
    chk("async_obj_out", obj_out, 1'b0);
    chk("async_lfsr", lfsr_state, 6'd0);
    tick();
    reset_bar = 1'b1;

    // Asynchronous reset while wrap_pulse is high.
    pulse_obj_reset();
    measure_gap(0, 0, 0, 0, n);
    chk("gap_pre_async_wrap", n, 160);
    #2;
    reset_bar = 1'b0;
    #1;
    chk("async_wrap_drop", wrap_pulse, 1'b0);
    tick();
    reset_bar = 1'b1;

    // obj_reset on the wrap step: no wrap_pulse, counter restarts.
    pulse_obj_reset();
    repeat (159) tick();
    chk("pre_wrap_no_pulse", wrap_pulse, 1'b0);
    obj_reset = 1'b1;
    tick();
    obj_reset = 1'b0;
    chk("clr_wins_wrap", wrap_pulse, 1'b0);
    chk("clr_wins_lfsr", lfsr_state, 6'd0);
    measure_gap(0, 0, 0, 0, n);
    chk("gap_after_clr", n, 160);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tia_object_position_counter.md
Name: tia_object_position_counter

Overview:
- Parametrised horizontal position counter for TIA movable objects (missiles, ball, player-start logic). It generalises the fixed 6-bit missile counter.
- An LFSR step counter is advanced by a pixel phase divider. It decodes main and copy start points and drives a variable-width object serial output.
- Adds configurable line period, pixel-per-step ratio, 1/2/4/8-pixel width and explicit HMOVE extra-clock injection.
- Sits between the TIA register file (RESxx, ENAxx, NUSIZx, HMOVE strobes) and the playfield/priority mux.

Parameters:
- LFSR_WIDTH, 6, step counter width; must satisfy 2^LFSR_WIDTH-1 >= PERIOD_STEPS.
- PERIOD_STEPS, 40, LFSR steps per scan line; the default gives 160 pixels with PHASE_BITS=2.
- PHASE_BITS, 2, pixels per LFSR step = 2^PHASE_BITS.

Ports:
- clk  in  1  single system clock.
- reset_bar  in  1  asynchronous active-low reset.
- pix_en  in  1  colour-clock enable; one pixel per cycle where high.
- count_en  in  1  motion enable (mec); when low, phase and LFSR hold.
- extra_clk  in  1  single-cycle HMOVE extra motion pulse.
- obj_reset  in  1  RESxx strobe, single cycle.
- lock  in  1  lock-to-player (RESMP); holds counter reset and forces output low.
- enable  in  1  object graphic enable (ENAxx).
- size  in  2  width code: 0..3 gives 1, 2, 4, 8 pixels.
- copies  in  3  NUSIZ copy code.
- obj_out  out  1  registered object serial output.
- wrap_pulse  out  1  one-clk pulse on the step into index 0.
- lfsr_state  out  LFSR_WIDTH  current LFSR value (debug/verification).

Behaviour:
- LFSR next state = {q[W-2:0], ~(q[W-1]^q[W-2])}; the reset value is all zeros.
- Step index k is the number of advances since the last zero. Decodes compare q against lfsr_state(k), computed by a constant function at elaboration.
- Advance event adv:
  - adv = pix_en & count_en & ~lock, plus extra_clk.
  - When both terms are active in one cycle, the phase counter advances by 2.
  - When phase wraps from 2^PHASE_BITS-1, the LFSR steps. At most one LFSR step occurs per clk; a double advance crossing the boundary steps once and carries the remainder in phase.
- Wrap:
  - The step from index PERIOD_STEPS-1 loads all zeros and asserts wrap_pulse for one clk.
  - The all-ones lock-up state also loads zeros on its next step, without wrap_pulse.
- Start decode:
  - Main copy start fires on the wrap step.
  - Copy offsets in steps: close 4, medium 8, wide 16.
  - copies codes:
    - 000: main only.
    - 001: +4.
    - 010: +8.
    - 011: +4 and +8.
    - 100: +16.
    - 110: +8 and +16.
    - 101 and 111: main only.
  - Offsets >= PERIOD_STEPS are never decoded.
- Output:
  - A start loads the width counter with 2^size on the same clk.
  - obj_out is high from the next clk for 2^size adv events, gated by enable & ~lock.
  - A new start during an active width reloads the counter.
  - size changes mid-object take effect on the next start only.
- obj_reset:
  - Clears phase, LFSR and width counter on the next clk; obj_out goes low next clk.
  - No start is generated; the main copy appears at the next wrap, PERIOD_STEPS*2^PHASE_BITS adv events later.
  - obj_reset in the same cycle as adv: reset wins.
- lock high: same as a continuous obj_reset. On release, counting resumes from index 0.
- Async reset: obj_out, wrap_pulse, phase, LFSR and width counter all go to 0; lfsr_state reads 0.

Optional Feature:
- OBJ_COPY_DECODE_EN:
  - Defined: copies are decoded as above.
  - Undefined: the copies port is ignored and only the main copy is produced (saves decode logic for ball-style objects).

Test Plan:
- Defaults, pix_en=count_en=1, enable=1, size=0, copies=000; obj_reset at cycle 0 -> wrap_pulse at cycle 160; obj_out high for 1 clk at cycle 161; period repeats every 160 cycles.
- size=3, copies=011 -> obj_out high 8 cycles starting at 1, 17 and 33 cycles after each wrap_pulse; with OBJ_COPY_DECODE_EN undefined, only the first burst.
- Two extra_clk pulses per line with pix_en=1 -> wrap_pulse spacing shrinks to 158 cycles; count_en=0 for 10 cycles -> spacing grows to 170.
- lock=1 for 50 cycles mid-line -> obj_out=0 and lfsr_state=0 throughout; wrap occurs 160 cycles after lock falls.
- reset_bar low mid-burst (size=2) -> obj_out and wrap_pulse drop immediately; obj_reset coincident with a wrap step -> no wrap_pulse and lfsr_state=0.
